// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 8N1 frames, 3-sample majority vote at mid-bit,
// single-entry output register with valid/ready handshake and overrun/framing pulses.
module uart_rx_oversample #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int SAMPLE_PERIOD = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TICK_W        = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int IDX_W         = $clog2(OVERSAMPLE);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]  IDX_V0    = IDX_W'(OVERSAMPLE / 2 - 1);
   localparam logic [IDX_W-1:0]  IDX_V1    = IDX_W'(OVERSAMPLE / 2);
   localparam logic [IDX_W-1:0]  IDX_V2    = IDX_W'(OVERSAMPLE / 2 + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state;
   logic              sync_ff1;
   logic              sync_ff2;
   logic [TICK_W-1:0] tick_cnt;
   logic [IDX_W-1:0]  sample_idx;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift_reg;
   logic              samp0;
   logic              samp1;

   logic rx;
   logic tick;
   logic vote;
   logic vote_point;
   logic bit_end;

   // The third vote sample is the live synchronized line, so the decision
   // is available on the same tick that takes the last sample.
   always_comb begin
      rx         = sync_ff2;
      tick       = (state != IDLE) && (tick_cnt == TICK_LAST);
      vote       = (samp0 & samp1) | (samp0 & rx) | (samp1 & rx);
      vote_point = tick && (sample_idx == IDX_V2);
      bit_end    = tick && (sample_idx == IDX_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         sync_ff1       <= 1'b1;
         sync_ff2       <= 1'b1;
         tick_cnt       <= '0;
         sample_idx     <= '0;
         bit_cnt        <= '0;
         shift_reg      <= '0;
         samp0          <= 1'b1;
         samp1          <= 1'b1;
         data_out       <= 8'h00;
         data_out_valid <= 1'b0;
         framing_error  <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         sync_ff1      <= serial_in;
         sync_ff2      <= sync_ff1;
         framing_error <= 1'b0;
         overrun       <= 1'b0;

         if (data_out_valid && data_out_ready)
            data_out_valid <= 1'b0;

         if (state != IDLE) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
               sample_idx <= (sample_idx == IDX_LAST) ? '0 : sample_idx + 1'b1;
               if (sample_idx == IDX_V0)
                  samp0 <= rx;
               if (sample_idx == IDX_V1)
                  samp1 <= rx;
            end
         end

         case (state)
            IDLE: begin
               if (!rx) begin
                  state      <= START;
                  tick_cnt   <= '0;
                  sample_idx <= '0;
                  bit_cnt    <= '0;
               end
            end

            START: begin
               if (vote_point && vote)
                  state <= IDLE;
               else if (bit_end)
                  state <= DATA;
            end

            DATA: begin
               if (vote_point)
                  shift_reg <= {vote, shift_reg[7:1]};
               if (bit_end) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= STOP;
               end
            end

            // Leave at mid-stop so a following start edge is never missed.
            STOP: begin
               if (vote_point) begin
                  state <= IDLE;
                  if (vote) begin
                     if (!data_out_valid || data_out_ready) begin
                        data_out       <= shift_reg;
                        data_out_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     framing_error <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; even, >=8.
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port serial_in, input, 1, asynchronous line, idle high.
REQ-007 Port data_out, output, 8, received byte, LSB first on line.
REQ-008 Port data_out_valid, output, 1, data_out holds an unconsumed byte.
REQ-009 Port data_out_ready, input, 1, consumer accepts byte when high with valid.
REQ-010 Port framing_error, output, 1, one-cycle pulse, stop bit sampled low.
REQ-011 Port overrun, output, 1, one-cycle pulse, completed byte dropped.

Function
REQ-012 serial_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 A tick counter SHALL count 0..SAMPLE_PERIOD-1, SAMPLE_PERIOD = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; a tick fires on wrap.
REQ-014 Ticks SHALL only advance in non-IDLE states; counter and sample index clear on entry to START.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on first clock the synchronized line is 0.
REQ-017 Bit value SHALL be majority of 3 samples at sample indices OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-018 START: after voting, if start bit votes 1 (glitch) -> IDLE, nothing reported; at sample index OVERSAMPLE-1 with vote 0 -> DATA.
REQ-019 DATA: 8 bits, each OVERSAMPLE ticks, voted bit shifted in LSB first; after 8th bit -> STOP.
REQ-020 STOP: after voting at mid-bit, vote 1 -> byte complete; vote 0 -> framing_error pulse, byte discarded; either case -> IDLE the clock after the vote (no wait for end of stop bit).
REQ-021 Byte completion: if data_out_valid=0, or data_out_valid=1 and data_out_ready=1 in the same cycle, load data_out and set data_out_valid=1 next cycle.
REQ-022 Byte completion with data_out_valid=1 and data_out_ready=0: keep old data_out, drop new byte, pulse overrun.
REQ-023 data_out_valid SHALL clear the cycle after valid&ready, unless REQ-021 simultaneous load.
REQ-024 data_out SHALL be stable while data_out_valid=1.
REQ-025 Receive FSM SHALL run independently of the output handshake; backpressure never stalls reception.
REQ-026 A low line in IDLE immediately after STOP SHALL start a new frame (back-to-back frames).
REQ-027 A continuous low line (break) SHALL give one framing_error per frame, no data.

Reset
REQ-028 On rst=1 at a clock edge: FSM=IDLE, counters=0, shift reg=0, data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0, synchronizer flops=1.
REQ-029 rst mid-frame SHALL abandon the frame with no output or error pulse; reception resumes on next falling edge after rst drops.

Verification (CLOCK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16: 10 clk/tick, 160 clk/bit)
REQ-030 Frame 0xA5, ready=1 -> data_out=8'hA5, valid high exactly one cycle, no error pulses.
REQ-031 Low pulse of 40 clk then high -> FSM back to IDLE, no valid, no framing_error.
REQ-032 Frame 0x3C with stop bit low -> framing_error one pulse, valid stays 0.
REQ-033 Frames 0x11 then 0x22 back-to-back, ready=0 -> data_out=8'h11 held, overrun one pulse on 2nd completion; then ready=1 -> valid clears.
REQ-034 Frame 0x5A with single-tick 0 glitch injected at mid-bit sample of bit 3 (true value 1) -> data_out=8'h5A via majority vote.
REQ-035 rst asserted during bit 4 of frame 0xFF, then valid frame 0x81 -> only 8'h81 delivered, no error pulses.
